// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared types and encodings for the multicycle RV32I-subset controller:
// FSM state enum, instruction classes, opcode/funct localparams and the
// ALUctrl / ImmSrc / ResultSrc encodings seen by the datapath.
// No ports (package).
// ----------------------------------------------------------------------------
package mc_pkg;

    // State encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_JAL,
        CLS_LUI,
        CLS_ILL
    } iclass_t;

    // Opcodes
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // funct3 / funct7 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALUctrl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ResultSrc
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode
// Combinational instruction decoder for the multicycle controller. Maps the
// instruction register contents to an instruction class plus the ALU and
// immediate controls. Anything outside the supported subset (opcode, funct3
// or funct7) decodes to CLS_ILL with legal=0.
// Ports:
//   instr   in  32  instruction register contents
//   iclass  out     instruction class (mc_pkg::iclass_t)
//   aluctrl out  3  ALU operation
//   immsrc  out  3  immediate format
//   alusrc  out  1  ALU operand B: 0=RD2, 1=ImmOp
//   legal   out  1  instruction is in the supported subset
// ----------------------------------------------------------------------------
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output logic [2:0]  aluctrl,
    output logic [2:0]  immsrc,
    output logic        alusrc,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices are consumed by the datapath, not by control.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a variable unassigned, which would infer a latch.
        iclass  = CLS_ILL;
        aluctrl = ALU_ADD;
        immsrc  = IMM_I;
        alusrc  = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin iclass = CLS_R; aluctrl = ALU_ADD; end
                        F3_AND:  begin iclass = CLS_R; aluctrl = ALU_AND; end
                        F3_OR:   begin iclass = CLS_R; aluctrl = ALU_OR;  end
                        F3_SLT:  begin iclass = CLS_R; aluctrl = ALU_SLT; end
                        default: ;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    iclass  = CLS_R;
                    aluctrl = ALU_SUB;
                end
            end
            OP_I: begin
                alusrc = 1'b1;
                case (funct3)
                    F3_ADD:  begin iclass = CLS_I; aluctrl = ALU_ADD; end
                    F3_AND:  begin iclass = CLS_I; aluctrl = ALU_AND; end
                    F3_OR:   begin iclass = CLS_I; aluctrl = ALU_OR;  end
                    F3_SLT:  begin iclass = CLS_I; aluctrl = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                alusrc = 1'b1;
                if (funct3 == F3_WORD) iclass = CLS_LW;
            end
            OP_SW: begin
                alusrc = 1'b1;
                immsrc = IMM_S;
                if (funct3 == F3_WORD) iclass = CLS_SW;
            end
            OP_BR: begin
                aluctrl = ALU_SUB;
                immsrc  = IMM_B;
                if (funct3 == F3_BEQ || funct3 == F3_BNE) iclass = CLS_BR;
            end
            OP_JAL: begin
                iclass = CLS_JAL;
                immsrc = IMM_J;
            end
            OP_LUI: begin
                // Datapath forces ALU operand A to zero, so add yields ImmOp.
                iclass = CLS_LUI;
                alusrc = 1'b1;
                immsrc = IMM_U;
            end
            default: ;
        endcase
    end

    assign legal = (iclass != CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencer for the multicycle RV32I-subset core. Steps the shared datapath
// through IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every
// enable and mux select. Instruction and data accesses share one memory port
// through mem_req/mem_ack. Unsupported instructions park the FSM in TRAP
// with the sticky illegal flag set; only reset leaves TRAP.
// Outputs are decoded combinationally from the state register, instr, Eq and
// mem_ack; state and illegal are the only control registers.
// Optional build macro: MC_PERF_CNT_EN adds the cyc_cnt / ret_cnt counters.
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   instr[DW]            instruction register contents (valid from DECODE)
//   Eq                   ALU equality flag
//   mem_ack              memory access complete (looked at only while mem_req)
//   mem_req, mem_we      memory request / write strobe
//   AdrSrc               memory address: 0=PC, 1=ALU result
//   IRWrite, PCWrite     instruction register / PC load
//   PCsrc                0=PC+4, 1=PC+ImmOp
//   RegWrite             register file write enable
//   ResultSrc[2]         00=ALU, 01=memory data, 10=PC+4
//   ALUsrc, ALUctrl[3]   ALU operand B select and operation
//   ImmSrc[3]            immediate format
//   state_o[3]           current state encoding
//   retired              one-cycle pulse per completed instruction
//   illegal              sticky, set on entering TRAP
//   cyc_cnt, ret_cnt[DW] active-cycle / retired-instruction counters (macro)
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instr,
    input  logic          Eq,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic          AdrSrc,
    output logic          IRWrite,
    output logic          PCWrite,
    output logic          PCsrc,
    output logic          RegWrite,
    output logic [1:0]    ResultSrc,
    output logic          ALUsrc,
    output logic [2:0]    ALUctrl,
    output logic [2:0]    ImmSrc,
    output logic [2:0]    state_o,
    output logic          retired,
    output logic          illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [DW-1:0] cyc_cnt,
    output logic [DW-1:0] ret_cnt
`endif
);

    state_t     state;
    iclass_t    iclass;
    logic [2:0] dec_aluctrl;
    logic [2:0] dec_immsrc;
    logic       dec_alusrc;
    logic       dec_legal;
    logic       is_bne;

    mc_decode u_decode (
        .instr   (instr[31:0]),
        .iclass  (iclass),
        .aluctrl (dec_aluctrl),
        .immsrc  (dec_immsrc),
        .alusrc  (dec_alusrc),
        .legal   (dec_legal)
    );

    // funct3[0] separates bne from beq once the class is known to be a branch.
    assign is_bne  = instr[12];
    assign state_o = state;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ack) state <= S_DECODE;
                S_DECODE: begin
                    if (!dec_legal) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (iclass)
                        CLS_LW, CLS_SW: state <= S_MEM;
                        CLS_BR:         state <= S_FETCH;
                        default:        state <= S_WB;
                    endcase
                end
                S_MEM:    if (mem_ack) state <= (iclass == CLS_SW) ? S_FETCH : S_WB;
                S_WB:     state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default: begin
                    // Unused encoding: treat like an illegal instruction.
                    state   <= S_TRAP;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALU;
        ALUsrc    = 1'b0;
        ALUctrl   = ALU_ADD;
        ImmSrc    = IMM_I;
        retired   = 1'b0;

        // ALU/immediate controls follow the decoded instruction for its whole
        // execution so address and result paths stay stable through MEM/WB.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            ALUsrc  = dec_alusrc;
            ALUctrl = dec_aluctrl;
            ImmSrc  = dec_immsrc;
        end

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ack;
            end
            S_EXEC: begin
                if (iclass == CLS_BR) begin
                    PCWrite = 1'b1;
                    PCsrc   = is_bne ? !Eq : Eq;
                    retired = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                mem_we  = (iclass == CLS_SW);
                if (iclass == CLS_SW && mem_ack) begin
                    PCWrite = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                retired  = 1'b1;
                PCsrc    = (iclass == CLS_JAL);
                case (iclass)
                    CLS_LW:  ResultSrc = RES_MEM;
                    CLS_JAL: ResultSrc = RES_PC4;
                    default: ResultSrc = RES_ALU;
                endcase
            end
            default: ;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP) cyc_cnt <= cyc_cnt + DW'(1);
            if (retired) ret_cnt <= ret_cnt + DW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table-driven bench for multicycle_ctrl. Each table row is one clock cycle:
// the inputs to drive and the outputs expected during that cycle. Expected
// values go into a scoreboard queue when a row is driven and are popped and
// compared at the following falling edge. Hand-written sequences cover the
// asynchronous reset cases and a funct7-illegal instruction.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        Eq;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCsrc;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic [2:0]  ImmSrc;
    logic [2:0]  state_o;
    logic        retired;
    logic        illegal;

    multicycle_ctrl #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .Eq        (Eq),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCsrc     (PCsrc),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUsrc    (ALUsrc),
        .ALUctrl   (ALUctrl),
        .ImmSrc    (ImmSrc),
        .state_o   (state_o),
        .retired   (retired),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stb = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite}
    // dec = {ALUsrc, ALUctrl[2:0], ImmSrc[2:0]}
    typedef struct packed {
        logic [2:0] st;
        logic [6:0] stb;
        logic [1:0] rs;
        logic [6:0] dec;
        logic       ret;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        logic        ack;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] I_ADDI = 32'h00500513;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0050A223;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_BNE  = 32'h00001463;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_SLT  = 32'h00B52533;
    localparam logic [31:0] I_ORI  = 32'h00356513;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MUL  = 32'h02B50533;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t zero_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic [6:0] stb,
                                input logic [1:0] rs, input logic [6:0] dec,
                                input logic ret, input logic ill);
        exp_t e;
        e.st = st; e.stb = stb; e.rs = rs; e.dec = dec; e.ret = ret; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.st  = state_o;
        s.stb = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite};
        s.rs  = ResultSrc;
        s.dec = {ALUsrc, ALUctrl, ImmSrc};
        s.ret = retired;
        s.ill = illegal;
        return s;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got st=%0d stb=%b rs=%b dec=%b ret=%b ill=%b, want st=%0d stb=%b rs=%b dec=%b ret=%b ill=%b",
                     name, act.st, act.stb, act.rs, act.dec, act.ret, act.ill,
                     exp.st, exp.stb, exp.rs, exp.dec, exp.ret, exp.ill);
        else
            n_pass++;
    endtask

    // Called just after a rising edge; drives one cycle, checks it at the
    // falling edge, and returns just after the next rising edge.
    task automatic apply(input string name, input logic [31:0] ins,
                         input logic e, input logic a, input exp_t x);
        instr   = ins;
        Eq      = e;
        mem_ack = a;
        sb.push_back(x);
        @(negedge clk);
        check(name, sample(), sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] ins, input logic e, input logic a, input exp_t x);
        vec_t v;
        v.instr = ins; v.eq = e; v.ack = a; v.exp = x;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        zero_e = '0;

        // addi x10,x0,5 : IDLE, FETCH, DECODE, EXEC, WB
        add(I_ADDI, 0, 1, mk(3'd0, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_ADDI, 0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_ADDI, 0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_ADDI, 0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b1_000_000, 0, 0));
        add(I_ADDI, 0, 1, mk(3'd5, 7'b0000101, 2'b00, 7'b1_000_000, 1, 0));
        // lw: one FETCH wait, two MEM waits
        add(I_LW,   0, 0, mk(3'd1, 7'b1000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_LW,   0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_LW,   0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_LW,   0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b1_000_000, 0, 0));
        add(I_LW,   0, 0, mk(3'd4, 7'b1010000, 2'b00, 7'b1_000_000, 0, 0));
        add(I_LW,   0, 0, mk(3'd4, 7'b1010000, 2'b00, 7'b1_000_000, 0, 0));
        add(I_LW,   0, 1, mk(3'd4, 7'b1010000, 2'b00, 7'b1_000_000, 0, 0));
        add(I_LW,   0, 1, mk(3'd5, 7'b0000101, 2'b01, 7'b1_000_000, 1, 0));
        // sw: one MEM wait, PCWrite/retired only on the ack cycle
        add(I_SW,   0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SW,   0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SW,   0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b1_000_001, 0, 0));
        add(I_SW,   0, 0, mk(3'd4, 7'b1110000, 2'b00, 7'b1_000_001, 0, 0));
        add(I_SW,   0, 1, mk(3'd4, 7'b1110100, 2'b00, 7'b1_000_001, 1, 0));
        // beq taken, beq not taken, bne with Eq=1 (not taken)
        add(I_BEQ,  1, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BEQ,  1, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BEQ,  1, 1, mk(3'd3, 7'b0000110, 2'b00, 7'b0_001_010, 1, 0));
        add(I_BEQ,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BEQ,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BEQ,  0, 1, mk(3'd3, 7'b0000100, 2'b00, 7'b0_001_010, 1, 0));
        add(I_BNE,  1, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BNE,  1, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BNE,  1, 1, mk(3'd3, 7'b0000100, 2'b00, 7'b0_001_010, 1, 0));
        // jal x1,16
        add(I_JAL,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_JAL,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_JAL,  0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b0_000_011, 0, 0));
        add(I_JAL,  0, 1, mk(3'd5, 7'b0000111, 2'b10, 7'b0_000_011, 1, 0));
        // sub, slt, ori, lui
        add(I_SUB,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SUB,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SUB,  0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b0_001_000, 0, 0));
        add(I_SUB,  0, 1, mk(3'd5, 7'b0000101, 2'b00, 7'b0_001_000, 1, 0));
        add(I_SLT,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SLT,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_SLT,  0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b0_101_000, 0, 0));
        add(I_SLT,  0, 1, mk(3'd5, 7'b0000101, 2'b00, 7'b0_101_000, 1, 0));
        add(I_ORI,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_ORI,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_ORI,  0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b1_011_000, 0, 0));
        add(I_ORI,  0, 1, mk(3'd5, 7'b0000101, 2'b00, 7'b1_011_000, 1, 0));
        add(I_LUI,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_LUI,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_LUI,  0, 1, mk(3'd3, 7'b0000000, 2'b00, 7'b1_000_100, 0, 0));
        add(I_LUI,  0, 1, mk(3'd5, 7'b0000101, 2'b00, 7'b1_000_100, 1, 0));
        // 0xFFFFFFFF: TRAP, illegal held, acks ignored
        add(I_BAD,  0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BAD,  0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        add(I_BAD,  0, 1, mk(3'd7, 7'b0000000, 2'b00, 7'b0_000_000, 0, 1));
        add(I_BAD,  1, 1, mk(3'd7, 7'b0000000, 2'b00, 7'b0_000_000, 0, 1));
        add(I_ADDI, 0, 1, mk(3'd7, 7'b0000000, 2'b00, 7'b0_000_000, 0, 1));

        // Reset with inputs active: everything must read zero.
        rst = 1'b0; instr = I_ADDI; Eq = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", sample(), zero_e);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("row%0d", i), vecs[i].instr, vecs[i].eq, vecs[i].ack, vecs[i].exp);

        // Async reset out of TRAP, between clock edges.
        #2 rst = 1'b0;
        #1 check("reset_in_trap", sample(), zero_e);
        @(posedge clk); #1;
        rst = 1'b1;
        apply("restart_idle",  I_MUL, 0, 0, mk(3'd0, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        apply("restart_fetch", I_MUL, 0, 0, mk(3'd1, 7'b1000000, 2'b00, 7'b0_000_000, 0, 0));

        // Async reset while a fetch is outstanding drops mem_req at once.
        #2 rst = 1'b0;
        #1 check("reset_mid_fetch", sample(), zero_e);
        @(posedge clk); #1;
        rst = 1'b1;

        // funct7 outside the subset (mul) must also trap.
        apply("mul_idle",   I_MUL, 0, 1, mk(3'd0, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        apply("mul_fetch",  I_MUL, 0, 1, mk(3'd1, 7'b1001000, 2'b00, 7'b0_000_000, 0, 0));
        apply("mul_decode", I_MUL, 0, 1, mk(3'd2, 7'b0000000, 2'b00, 7'b0_000_000, 0, 0));
        apply("mul_trap0",  I_MUL, 0, 1, mk(3'd7, 7'b0000000, 2'b00, 7'b0_000_000, 0, 1));
        apply("mul_trap1",  I_MUL, 1, 0, mk(3'd7, 7'b0000000, 2'b00, 7'b0_000_000, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
